// File: rtl/operand_fwd_hazard.sv
// -----------------------------------------------------------------------------
// operand_fwd_hazard
//
// D-stage operand forwarding and hazard unit for a 5-stage MIPS pipeline.
// A 3-entry shift pipeline (E, M, W) records the pending register writes of
// the instructions ahead of D. For every read port the block picks the
// register-file value or one of the E/M/W forwarding buses. It raises a stall
// when the youngest producer of an operand cannot deliver it by the time the
// reader consumes it.
//
// Ports
//   clk, reset      clock, synchronous active-high reset
//   wen_d, a3_d     D-stage instruction write enable / destination register
//   tnew_d          cycles after entering E until its result is on a bus
//   flush           kill the instruction entering E (bubble)
//   ra_d, tuse_d    per-port read address / cycles until operand is consumed
//   rf_rdata        per-port register-file read data
//   fwd_*_data      E/M/W stage result buses
//   opnd_d          per-port selected operand
//   fwd_sel_d       per-port select: 0 RF, 1 E, 2 M, 3 W
//   pend_d          per-port: operand not valid yet, re-resolve later
//   stall           freeze PC/D and inject a bubble into E
// -----------------------------------------------------------------------------
module operand_fwd_hazard #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NPORT  = 2,
    parameter int T_W    = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wen_d,
    input  logic [ADDR_W-1:0]         a3_d,
    input  logic [T_W-1:0]            tnew_d,
    input  logic                      flush,
    input  logic [NPORT*ADDR_W-1:0]   ra_d,
    input  logic [NPORT*T_W-1:0]      tuse_d,
    input  logic [NPORT*DATA_W-1:0]   rf_rdata,
    input  logic [DATA_W-1:0]         fwd_e_data,
    input  logic [DATA_W-1:0]         fwd_m_data,
    input  logic [DATA_W-1:0]         fwd_w_data,
    output logic [NPORT*DATA_W-1:0]   opnd_d,
    output logic [NPORT*2-1:0]        fwd_sel_d,
    output logic [NPORT-1:0]          pend_d,
    output logic                      stall
);

    // Stage index inside the tracking pipeline: 0 = E, 1 = M, 2 = W.
    localparam int NSTG = 3;

    logic [NSTG-1:0]   trk_wen_q;
    logic [NSTG-1:0]   trk_wen_d;
    logic [ADDR_W-1:0] trk_a3_q   [NSTG];
    logic [ADDR_W-1:0] trk_a3_d   [NSTG];
    logic [T_W-1:0]    trk_tnew_q [NSTG];
    logic [T_W-1:0]    trk_tnew_d [NSTG];

    logic              bubble_s;
    logic [NPORT-1:0]  stall_p_s;

    // Counts down toward "result available" but never wraps below zero.
    function automatic logic [T_W-1:0] sat_dec(input logic [T_W-1:0] t);
        logic [T_W-1:0] r;
        if (t != {T_W{1'b0}}) begin
            r = t - {{(T_W-1){1'b0}}, 1'b1};
        end else begin
            r = {T_W{1'b0}};
        end
        return r;
    endfunction

    // Next state of the tracking pipeline; M and W advance even while stalled.
    always_comb begin
        bubble_s = stall | flush;

        // A stalled or flushed D instruction must not enter E; stall and
        // flush together still produce exactly one bubble.
        if (bubble_s) begin
            trk_wen_d[0]  = 1'b0;
            trk_a3_d[0]   = {ADDR_W{1'b0}};
            trk_tnew_d[0] = {T_W{1'b0}};
        end else begin
            // Writes to $zero are dropped here so they can never match.
            trk_wen_d[0]  = wen_d & (a3_d != {ADDR_W{1'b0}});
            trk_a3_d[0]   = a3_d;
            trk_tnew_d[0] = tnew_d;
        end

        trk_wen_d[1]  = trk_wen_q[0];
        trk_a3_d[1]   = trk_a3_q[0];
        trk_tnew_d[1] = sat_dec(trk_tnew_q[0]);

        // Anything that reaches W is on the W bus by definition.
        trk_wen_d[2]  = trk_wen_q[1];
        trk_a3_d[2]   = trk_a3_q[1];
        trk_tnew_d[2] = {T_W{1'b0}};
    end

    // Tracking pipeline registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            trk_wen_q <= {NSTG{1'b0}};
            for (int s = 0; s < NSTG; s++) begin
                trk_a3_q[s]   <= {ADDR_W{1'b0}};
                trk_tnew_q[s] <= {T_W{1'b0}};
            end
        end else begin
            trk_wen_q <= trk_wen_d;
            for (int s = 0; s < NSTG; s++) begin
                trk_a3_q[s]   <= trk_a3_d[s];
                trk_tnew_q[s] <= trk_tnew_d[s];
            end
        end
    end

    // Per-port operand resolution against the current tracking entries.
    always_comb begin : resolve_b
        logic [ADDR_W-1:0] ra_v;
        logic [T_W-1:0]    tuse_v;
        logic [T_W-1:0]    tnew_v;
        logic [NSTG-1:0]   hit_v;
        logic [1:0]        sel_v;
        logic [DATA_W-1:0] bus_v;

        opnd_d    = rf_rdata;
        fwd_sel_d = {(NPORT*2){1'b0}};
        pend_d    = {NPORT{1'b0}};
        stall_p_s = {NPORT{1'b0}};
        ra_v      = {ADDR_W{1'b0}};
        tuse_v    = {T_W{1'b0}};
        tnew_v    = {T_W{1'b0}};
        hit_v     = {NSTG{1'b0}};
        sel_v     = 2'd0;
        bus_v     = {DATA_W{1'b0}};

        for (int p = 0; p < NPORT; p++) begin
            ra_v   = ra_d[p*ADDR_W +: ADDR_W];
            tuse_v = tuse_d[p*T_W +: T_W];

            for (int s = 0; s < NSTG; s++) begin
                hit_v[s] = trk_wen_q[s] && (trk_a3_q[s] == ra_v) &&
                           (ra_v != {ADDR_W{1'b0}});
            end

            // Only the youngest producer matters: an older ready value is
            // stale once a younger write to the same register is in flight.
            if (hit_v[0]) begin
                sel_v  = 2'd1;
                tnew_v = trk_tnew_q[0];
                bus_v  = fwd_e_data;
            end else if (hit_v[1]) begin
                sel_v  = 2'd2;
                tnew_v = trk_tnew_q[1];
                bus_v  = fwd_m_data;
            end else if (hit_v[2]) begin
                sel_v  = 2'd3;
                tnew_v = trk_tnew_q[2];
                bus_v  = fwd_w_data;
            end else begin
                sel_v  = 2'd0;
                tnew_v = {T_W{1'b0}};
                bus_v  = rf_rdata[p*DATA_W +: DATA_W];
            end

            if (sel_v == 2'd0) begin
                pend_d[p] = 1'b0;
            end else if (tnew_v == {T_W{1'b0}}) begin
                fwd_sel_d[p*2 +: 2]        = sel_v;
                opnd_d[p*DATA_W +: DATA_W] = bus_v;
            end else if (tnew_v <= tuse_v) begin
                // Producer will be ready in time; a later stage re-resolves.
                pend_d[p] = 1'b1;
            end else begin
                pend_d[p]    = 1'b1;
                stall_p_s[p] = 1'b1;
            end
        end
    end

    assign stall = |stall_p_s;

endmodule

// File: tb/tb_operand_fwd_hazard.sv
module tb_operand_fwd_hazard;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NPORT  = 2;
    localparam int T_W    = 2;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    wen_d;
    logic [ADDR_W-1:0]       a3_d;
    logic [T_W-1:0]          tnew_d;
    logic                    flush;
    logic [NPORT*ADDR_W-1:0] ra_d;
    logic [NPORT*T_W-1:0]    tuse_d;
    logic [NPORT*DATA_W-1:0] rf_rdata;
    logic [DATA_W-1:0]       fwd_e_data;
    logic [DATA_W-1:0]       fwd_m_data;
    logic [DATA_W-1:0]       fwd_w_data;
    logic [NPORT*DATA_W-1:0] opnd_d;
    logic [NPORT*2-1:0]      fwd_sel_d;
    logic [NPORT-1:0]        pend_d;
    logic                    stall;

    operand_fwd_hazard #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NPORT(NPORT), .T_W(T_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wen_d      (wen_d),
        .a3_d       (a3_d),
        .tnew_d     (tnew_d),
        .flush      (flush),
        .ra_d       (ra_d),
        .tuse_d     (tuse_d),
        .rf_rdata   (rf_rdata),
        .fwd_e_data (fwd_e_data),
        .fwd_m_data (fwd_m_data),
        .fwd_w_data (fwd_w_data),
        .opnd_d     (opnd_d),
        .fwd_sel_d  (fwd_sel_d),
        .pend_d     (pend_d),
        .stall      (stall)
    );

    always #5 clk = ~clk;

    // An instruction as it was issued into E: original tnew, not a counter.
    typedef struct {
        bit wen;
        int a3;
        int tnew;
    } op_t;

    typedef struct {
        logic [NPORT*DATA_W-1:0] opnd;
        logic [NPORT*2-1:0]      sel;
        logic [NPORT-1:0]        pend;
        logic                    stall;
        string                   name;
    } exp_t;

    exp_t  exp_q[$];
    op_t   hist[3];        // hist[k]: instruction that entered E k cycles ago
    bit    known = 1'b0;   // model valid once a reset edge has been seen
    int    n_vec = 0;
    int    n_err = 0;
    string tag   = "";

    // Predict this cycle's outputs, push them, then advance the model at the edge.
    task automatic step();
        exp_t e;
        bit   st;
        st     = 1'b0;
        e.opnd = rf_rdata;
        e.sel  = '0;
        e.pend = '0;
        e.name = tag;
        for (int p = 0; p < NPORT; p++) begin
            int ra;
            int tu;
            int age;
            ra  = int'(ra_d[p*ADDR_W +: ADDR_W]);
            tu  = int'(tuse_d[p*T_W +: T_W]);
            age = -1;
            if (ra != 0) begin
                for (int a = 2; a >= 0; a--) begin
                    if (hist[a].wen && hist[a].a3 == ra) age = a;
                end
            end
            if (age >= 0) begin
                int rem;
                // Remaining wait: original tnew minus cycles spent, zero in W.
                if (age == 2) rem = 0;
                else rem = (hist[age].tnew > age) ? hist[age].tnew - age : 0;
                if (rem == 0) begin
                    e.sel[p*2 +: 2] = 2'(age + 1);
                    e.opnd[p*DATA_W +: DATA_W] = (age == 0) ? fwd_e_data :
                                                 (age == 1) ? fwd_m_data : fwd_w_data;
                end else begin
                    e.pend[p] = 1'b1;
                    if (rem > tu) st = 1'b1;
                end
            end
        end
        e.stall = st;
        if (known) exp_q.push_back(e);
        @(posedge clk);
        if (reset) begin
            for (int k = 0; k < 3; k++) begin
                hist[k].wen = 1'b0; hist[k].a3 = 0; hist[k].tnew = 0;
            end
            known = 1'b1;
        end else begin
            hist[2] = hist[1];
            hist[1] = hist[0];
            if (st || flush) begin
                hist[0].wen = 1'b0; hist[0].a3 = 0; hist[0].tnew = 0;
            end else begin
                hist[0].wen = wen_d; hist[0].a3 = int'(a3_d); hist[0].tnew = int'(tnew_d);
            end
        end
        #1;
    endtask

    // Present one D-stage cycle with fresh random data on every bus.
    task automatic instr(input bit w, input int a3, input int tn, input bit fl,
                         input int ra0, input int tu0, input int ra1, input int tu1,
                         input string name);
        wen_d      = w;
        a3_d       = ADDR_W'(a3);
        tnew_d     = T_W'(tn);
        flush      = fl;
        ra_d       = {ADDR_W'(ra1), ADDR_W'(ra0)};
        tuse_d     = {T_W'(tu1), T_W'(tu0)};
        rf_rdata   = {$urandom(), $urandom()};
        fwd_e_data = $urandom();
        fwd_m_data = $urandom();
        fwd_w_data = $urandom();
        tag        = name;
        step();
    endtask

    // Monitor: compare every presented output against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if (opnd_d !== e.opnd || fwd_sel_d !== e.sel ||
                    pend_d !== e.pend || stall !== e.stall) begin
                    n_err++;
                    $display("FAIL %s: got opnd=%h sel=%b pend=%b stall=%b, expected opnd=%h sel=%b pend=%b stall=%b",
                             e.name, opnd_d, fwd_sel_d, pend_d, stall,
                             e.opnd, e.sel, e.pend, e.stall);
                end
            end
        end
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            hist[k].wen = 1'b0; hist[k].a3 = 0; hist[k].tnew = 0;
        end
        reset      = 1'b1;
        wen_d      = 1'b0;
        a3_d       = '0;
        tnew_d     = '0;
        flush      = 1'b0;
        ra_d       = {5'd0, 5'd8};
        tuse_d     = '0;
        rf_rdata   = {32'h0000_0022, 32'h0000_0011};
        fwd_e_data = 32'h0000_EEEE;
        fwd_m_data = 32'h0000_CAFE;
        fwd_w_data = 32'h0000_9999;
        tag        = "reset";
        step();
        step();
        reset = 1'b0;

        // ALU chain: producer tnew=1, then two consumers of r8.
        instr(1'b1, 8, 1, 1'b0, 0, 0, 0, 0, "alu_prod");
        instr(1'b0, 0, 0, 1'b0, 8, 1, 0, 0, "alu_use1");
        instr(1'b0, 0, 0, 1'b0, 8, 1, 0, 0, "alu_use2");

        // Load-use: two stall cycles, then forward from W.
        instr(1'b1, 9, 2, 1'b0, 0, 0, 0, 0, "ld_prod");
        for (int i = 0; i < 3; i++) instr(1'b0, 0, 0, 1'b0, 9, 0, 0, 0, "ld_use");

        // Write to $zero never forwards.
        instr(1'b1, 0, 0, 1'b0, 0, 0, 0, 0, "zero_prod");
        instr(1'b0, 0, 0, 1'b0, 0, 0, 0, 0, "zero_use");

        // Youngest producer wins.
        instr(1'b1, 5, 0, 1'b0, 0, 0, 0, 0, "prio_old");
        instr(1'b1, 5, 0, 1'b0, 0, 0, 0, 0, "prio_new");
        instr(1'b0, 0, 0, 1'b0, 5, 0, 5, 3, "prio_use");

        // tnew == tuse is in time, tnew > tuse stalls.
        instr(1'b1, 6, 2, 1'b0, 0, 0, 0, 0, "tuse_prod");
        instr(1'b0, 0, 0, 1'b0, 6, 2, 6, 1, "tuse_eq");
        instr(1'b0, 0, 0, 1'b0, 0, 0, 0, 0, "tuse_idle");
        instr(1'b0, 0, 0, 1'b0, 0, 0, 0, 0, "tuse_idle");

        // tnew=3 reaching W must be forwarded anyway.
        instr(1'b1, 12, 3, 1'b0, 0, 0, 0, 0, "t3_prod");
        for (int i = 0; i < 3; i++) instr(1'b0, 0, 0, 1'b0, 12, 0, 12, 3, "t3_use");

        // Flushed producer leaves nothing behind.
        instr(1'b1, 7, 2, 1'b1, 0, 0, 0, 0, "flush_prod");
        instr(1'b0, 0, 0, 1'b0, 7, 0, 7, 0, "flush_use");

        // Stall and flush together: single bubble.
        instr(1'b1, 11, 2, 1'b0, 0, 0, 0, 0, "sf_prod");
        instr(1'b1, 13, 0, 1'b1, 11, 0, 0, 0, "sf_both");
        instr(1'b0, 0, 0, 1'b0, 11, 0, 13, 0, "sf_after");

        // Reset during a stall clears it on the next cycle.
        instr(1'b1, 10, 3, 1'b0, 0, 0, 0, 0, "rst_prod");
        instr(1'b0, 0, 0, 1'b0, 10, 0, 0, 0, "rst_stall");
        reset = 1'b1;
        instr(1'b0, 0, 0, 1'b0, 10, 0, 0, 0, "rst_hold");
        reset = 1'b0;
        instr(1'b0, 0, 0, 1'b0, 10, 0, 10, 0, "rst_after");

        // Randomized traffic over a small register set so matches are frequent.
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 39) == 0);
            instr(1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3),
                  ($urandom_range(0, 7) == 0),
                  $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 3), "random");
        end
        reset = 1'b0;

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d predictions left unchecked, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
